// File: rtl/vga_cap_pkg.sv
// Shared types and helpers for the frame capture path.
package vga_cap_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        CAPTURE,
        DONE
    } cap_state_t;

    function automatic int unsigned frame_pixels(input int unsigned h_active,
                                                 input int unsigned v_active);
        return h_active * v_active;
    endfunction

endpackage

// File: rtl/frame_capture_if.sv
// Video stream in, frame-buffer write port out, for frame_capture.
interface frame_capture_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 19
);
    logic              i_vsync;
    logic              i_hsync;
    logic              i_de;
    logic [WIDTH-1:0]  i_data;
    logic              o_wr_en;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [WIDTH-1:0]  o_wr_data;

    // The write port has no back-pressure: each cycle with o_wr_en high
    // is one complete write of o_wr_data at o_wr_addr.
    modport master (
        output i_vsync, i_hsync, i_de, i_data,
        input  o_wr_en, o_wr_addr, o_wr_data
    );

    modport slave (
        input  i_vsync, i_hsync, i_de, i_data,
        output o_wr_en, o_wr_addr, o_wr_data
    );
endinterface

// File: rtl/sync_edge_det.sv
// Registers a sync-style signal and flags edges of the live input against
// the registered copy; the history resets to the signal's idle level.
module sync_edge_det #(
    parameter logic IDLE_LVL = 1'b1
) (
    input  logic clk,
    input  logic rstn,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic sig_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) sig_q <= IDLE_LVL;
        else       sig_q <= sig;
    end

    assign rise = sig & ~sig_q;
    assign fall = ~sig & sig_q;

endmodule

// File: rtl/frame_capture.sv
// Captures one grayscale frame on request into a raster-order write port.
// Define CAPTURE_THRESH_EN to write a binarized (all-ones/zero) mask instead.
module frame_capture
    import vga_cap_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19
) (
    input  logic              clk,
    input  logic              rstn,
    frame_capture_if.slave    vid,
    input  logic [WIDTH-1:0]  i_threshold,
    input  logic              i_start,
    input  logic              i_abort,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_frame_err,
    output cap_state_t        o_dbg_state,
    output logic              o_dbg_hsync
);

    localparam int PW = ADDR_W + 1;
    localparam logic [PW-1:0]    PIX_LIMIT = PW'(frame_pixels(H_ACTIVE, V_ACTIVE));
    localparam logic [CNT_W-1:0] H_REQ     = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_REQ     = CNT_W'(V_ACTIVE);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    cap_state_t        state, state_nxt;
    logic              vs_fall, de_fall;
    logic              vs_rise_unused, de_rise_unused;
    logic [CNT_W-1:0]  x_cnt, y_cnt;
    logic [PW-1:0]     addr;
    logic              pix_vld;
    logic [ADDR_W-1:0] pix_addr;
    logic [WIDTH-1:0]  pix_data;
    logic [WIDTH-1:0]  pix_val;

    sync_edge_det #(.IDLE_LVL(1'b1)) u_vs_edge (
        .clk  (clk),
        .rstn (rstn),
        .sig  (vid.i_vsync),
        .rise (vs_rise_unused),
        .fall (vs_fall)
    );

    sync_edge_det #(.IDLE_LVL(1'b0)) u_de_edge (
        .clk  (clk),
        .rstn (rstn),
        .sig  (vid.i_de),
        .rise (de_rise_unused),
        .fall (de_fall)
    );

`ifdef CAPTURE_THRESH_EN
    always_comb begin
        pix_val = (vid.i_data >= i_threshold) ? '1 : '0;
    end
`else
    logic unused_threshold;
    assign unused_threshold = ^i_threshold;
    always_comb begin
        pix_val = vid.i_data;
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Abort takes priority over a vsync edge seen in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_start) state_nxt = ARM;
            ARM: begin
                if (i_abort)      state_nxt = IDLE;
                else if (vs_fall) state_nxt = CAPTURE;
            end
            CAPTURE: begin
                if (i_abort)      state_nxt = IDLE;
                else if (vs_fall) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pixels pass through one staging register and then the output register,
    // so a pixel sampled at edge N is on the write port after edge N+1.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x_cnt         <= '0;
            y_cnt         <= '0;
            addr          <= '0;
            o_frame_err   <= 1'b0;
            pix_vld       <= 1'b0;
            pix_addr      <= '0;
            pix_data      <= '0;
            vid.o_wr_en   <= 1'b0;
            vid.o_wr_addr <= '0;
            vid.o_wr_data <= '0;
            o_dbg_hsync   <= 1'b1;
        end else begin
            o_dbg_hsync <= vid.i_hsync;
            vid.o_wr_en <= pix_vld;
            if (pix_vld) begin
                vid.o_wr_addr <= pix_addr;
                vid.o_wr_data <= pix_data;
            end
            pix_vld <= 1'b0;

            case (state)
                IDLE: begin
                    if (i_start) begin
                        o_frame_err <= 1'b0;
                        x_cnt       <= '0;
                        y_cnt       <= '0;
                        addr        <= '0;
                    end
                end
                CAPTURE: begin
                    if (!i_abort) begin
                        if (vid.i_de) begin
                            // Pixels past the end of the frame buffer are dropped.
                            if (addr < PIX_LIMIT) begin
                                pix_vld  <= 1'b1;
                                pix_addr <= addr[ADDR_W-1:0];
                                pix_data <= pix_val;
                                addr     <= addr + PW'(1);
                            end else begin
                                o_frame_err <= 1'b1;
                            end
                            x_cnt <= sat_inc(x_cnt);
                        end
                        if (de_fall) begin
                            if (x_cnt != H_REQ) o_frame_err <= 1'b1;
                            y_cnt <= sat_inc(y_cnt);
                            x_cnt <= '0;
                        end
                        if (vs_fall && (y_cnt != V_REQ)) o_frame_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy      = (state == ARM) || (state == CAPTURE);
    assign o_done      = (state == DONE);
    assign o_dbg_state = state;

endmodule

// File: doc/frame_capture.md
# frame_capture

Video-stream sink that captures one grayscale frame, on request, into a frame-buffer write port. It sits after the grayscale stage in the VGA/camera pipeline and consumes that stage's sync/DE/pixel stream. It writes pixels in raster order to a BRAM-style port for the pen-plotter image path. It also checks line length and line count, and flags a malformed frame.

## Interface
Parameters:
- WIDTH, 8: pixel width.
- H_ACTIVE, 640: required active pixels per line.
- V_ACTIVE, 480: required active lines per frame.
- ADDR_W, 19: write-address width; must satisfy 2^ADDR_W ≥ H_ACTIVE*V_ACTIVE.

Ports:
- clk  in  1  pixel clock; single clock domain.
- rstn  in  1  asynchronous, active-low reset.
- i_vsync  in  1  vertical sync, active-low.
- i_hsync  in  1  horizontal sync; unused except for passthrough debug.
- i_de  in  1  data enable, high on active pixels.
- i_data  in  WIDTH  gray pixel (R channel of gray stage).
- i_threshold  in  WIDTH  binarization level; used only with CAPTURE_THRESH_EN.
- i_start  in  1  one-cycle capture request.
- i_abort  in  1  one-cycle abort request.
- o_busy  out  1  high from accepted start until done/abort.
- o_done  out  1  one-cycle pulse when a frame completes.
- o_frame_err  out  1  sticky error for the last capture; cleared on next accepted start.
- o_wr_en  out  1  frame-buffer write strobe.
- o_wr_addr  out  ADDR_W  write address, raster order from 0.
- o_wr_data  out  WIDTH  write data.

## Operation
- FSM states:
  - IDLE: on i_start, go to ARM; o_busy=1; clear o_frame_err, x, y, addr.
  - ARM: wait for vsync falling edge (i_vsync 1→0, detected against its registered copy). On edge, go to CAPTURE.
  - CAPTURE: on each cycle with i_de=1, write i_data at addr; addr++, x++.
  - CAPTURE line end: on DE falling edge, set o_frame_err if x≠H_ACTIVE; then y++ and x=0.
  - CAPTURE frame end: on next vsync falling edge, set o_frame_err if y≠V_ACTIVE; go to DONE.
  - DONE: pulse o_done for one cycle, drop o_busy, return to IDLE.
- Address bound: once addr reaches H_ACTIVE*V_ACTIVE, further DE pixels are not written. o_frame_err is set and the write address never exceeds the last address.
- i_start outside IDLE is ignored.
- i_abort in ARM or CAPTURE returns to IDLE next cycle with no o_done; o_busy drops. Abort wins over a simultaneous vsync edge.
- i_start and a vsync falling edge in the same IDLE cycle: that edge is not used. Capture starts at the following frame.
- DE active during ARM (partial frame) is ignored.
- Counters: x is 16-bit, y is 16-bit, both saturating. Comparisons are unsigned.

## Timing
- Input to write port: 1-cycle latency. Pixel sampled with i_de=1 at edge N appears on o_wr_* after edge N+1, with o_wr_en high for exactly one cycle per pixel.
- o_done asserts the cycle after CAPTURE sees the terminating vsync edge. o_busy falls in the same cycle o_done rises.
- o_frame_err is valid no later than the o_done cycle.
- Reset values: o_busy=0, o_done=0, o_frame_err=0, o_wr_en=0, o_wr_addr=0, o_wr_data=0. FSM=IDLE, counters=0, sync history registers=1 (idle vsync level).
- Reset asserted mid-capture: all of the above apply immediately (asynchronous). No further writes occur until a new i_start.

## Configuration
- CAPTURE_THRESH_EN defined: o_wr_data = all-ones if i_data ≥ i_threshold, else 0. This is a 1-bit plotter mask widened to WIDTH. Latency is unchanged.
- Not defined: o_wr_data = i_data unchanged; i_threshold is ignored.

## Structure
- Shared package vga_cap_pkg:
  - typedef enum cap_state_t {IDLE, ARM, CAPTURE, DONE}.
  - Localparam CNT_W=16.
  - Function returning frame pixel count.
- One sub-module, sync_edge_det: registers a signal and emits rise/fall pulses. It is instanced for i_vsync and i_de, and resets to the idle level given by a parameter.

## Test plan
Use H_ACTIVE=8, V_ACTIVE=4, ADDR_W=5.
- Nominal frame:
  - Stimulus: start, then two frames of 4×8 DE with data=addr.
  - Required: 32 writes at addresses 0..31 with data 0..31; o_done once after the second vsync falling edge; o_frame_err=0; second frame not written.
- Short line:
  - Stimulus: line 2 has 7 DE pixels.
  - Required: 31 writes; o_frame_err=1 at o_done.
- Extra lines:
  - Stimulus: 5 lines.
  - Required: writes stop at address 31; o_frame_err=1; o_wr_addr never exceeds 31.
- Abort and re-arm:
  - Stimulus: i_abort after 10 writes; then i_start.
  - Required: o_busy falls next cycle, no o_done; new capture starts at address 0 with o_frame_err cleared.
- Reset and start collision:
  - Stimulus: rstn low mid-capture.
  - Required: all outputs 0 immediately and o_busy=0.
  - Stimulus: i_start in the same cycle as a vsync falling edge.
  - Required: capture begins at the next vsync edge.
- Threshold (CAPTURE_THRESH_EN defined):
  - Stimulus: i_threshold=128, data 127/128/255.
  - Required: o_wr_data 0x00/0xFF/0xFF.
